// File: rtl/cordic_preproc_if.sv
// Handshake and data bundle between the upstream source, the CORDIC pre-processor
// and the rotation unit that consumes its start vector.
interface cordic_preproc_if #(
  parameter int N = 32
);
  logic                trig_rot;
  logic signed [N-1:0] angle;
  logic signed [N-1:0] Xi;
  logic signed [N-1:0] Yi;
  logic                in_valid;
  logic                in_ready;

  logic signed [N-1:0] X0;
  logic signed [N-1:0] Y0;
  logic signed [N-1:0] Z0;
  logic                mode_o;
  logic                folded;
  logic                out_valid;
  logic                out_ready;

  modport slave (
    input  trig_rot, angle, Xi, Yi, in_valid, out_ready,
    output in_ready, X0, Y0, Z0, mode_o, folded, out_valid
  );

  modport master (
    output trig_rot, angle, Xi, Yi, in_valid, out_ready,
    input  in_ready, X0, Y0, Z0, mode_o, folded, out_valid
  );
endinterface

// File: rtl/cordic_preproc.sv
// Reduces a Q3.29 angle into [-pi/2, pi/2] and builds the matching CORDIC start
// vector, so the rotation unit's outputs need no post-correction.
module cordic_preproc #(
  parameter int                  N         = 32,
  parameter logic signed [N-1:0] K_GAIN    = 32'h136E9DB5,
  parameter logic signed [N-1:0] PI_Q      = 32'h6487ED51,
  parameter logic signed [N-1:0] HALF_PI_Q = 32'h3243F6A9
) (
  input  logic            clk,
  input  logic            rst,
  cordic_preproc_if.slave io
);

  localparam logic signed [N:0] PI_X      = {PI_Q[N-1], PI_Q};
  localparam logic signed [N:0] TWO_PI_X  = PI_X <<< 1;
  localparam logic signed [N:0] HALF_PI_X = {HALF_PI_Q[N-1], HALF_PI_Q};

  typedef enum logic [1:0] {IDLE, WRAP, FOLD, HOLD} state_t;

  state_t state, state_nxt;
  logic   in_ready_c, out_valid_c;

  logic signed [N-1:0] ang_p0, x_p0, y_p0;
  logic                mode_p0;
  logic signed [N:0]   ang_x, z_wrap, z_p1;
  logic signed [N-1:0] z_fold;
  logic                fold_c;

  logic signed [N-1:0] x0_q, y0_q, z0_q;
  logic                mode_q, folded_q;

  // Two's-complement negation that maps the most negative code to the most positive.
  function automatic logic signed [N-1:0] sat_neg(input logic signed [N-1:0] v);
    if (v == {1'b1, {(N-1){1'b0}}})
      return {1'b0, {(N-1){1'b1}}};
    else
      return -v;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state)
      IDLE: begin
        in_ready_c = 1'b1;
        if (io.in_valid) state_nxt = WRAP;
      end
      WRAP: state_nxt = FOLD;
      FOLD: state_nxt = HOLD;
      HOLD: begin
        out_valid_c = 1'b1;
        if (io.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_c;

  // Stage p0 -> p1: a single +/-2pi correction brings any [-4,4) angle into [-pi,pi].
  assign ang_x = {ang_p0[N-1], ang_p0};

  always_comb begin
    z_wrap = ang_x;
    if (ang_x > PI_X)
      z_wrap = ang_x - TWO_PI_X;
    else if (ang_x < -PI_X)
      z_wrap = ang_x + TWO_PI_X;
  end

  // Stage p1 -> out: the +/-pi fold; the result fits N bits, so modular N-bit math is exact.
  always_comb begin
    fold_c = 1'b0;
    z_fold = z_p1[N-1:0];
    if (z_p1 > HALF_PI_X) begin
      fold_c = 1'b1;
      z_fold = z_p1[N-1:0] - PI_Q;
    end else if (z_p1 < -HALF_PI_X) begin
      fold_c = 1'b1;
      z_fold = z_p1[N-1:0] + PI_Q;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && io.in_valid) begin
      ang_p0  <= io.angle;
      x_p0    <= io.trig_rot ? io.Xi : K_GAIN;
      y_p0    <= io.trig_rot ? io.Yi : '0;
      mode_p0 <= io.trig_rot;
    end
    if (state == WRAP) z_p1 <= z_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x0_q     <= '0;
      y0_q     <= '0;
      z0_q     <= '0;
      mode_q   <= 1'b0;
      folded_q <= 1'b0;
    end else if (state == FOLD) begin
      x0_q     <= fold_c ? sat_neg(x_p0) : x_p0;
      y0_q     <= fold_c ? sat_neg(y_p0) : y_p0;
      z0_q     <= z_fold;
      mode_q   <= mode_p0;
      folded_q <= fold_c;
    end
  end

  assign io.X0     = x0_q;
  assign io.Y0     = y0_q;
  assign io.Z0     = z0_q;
  assign io.mode_o = mode_q;
  assign io.folded = folded_q;

endmodule
